// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
//   Bundles every signal the instruction-fetch stage exchanges with the rest
//   of the pipeline: hazard/redirect controls coming in, the combinational
//   instruction ROM port, the IF/ID pipeline register going out to decode,
//   and the debug status (out-of-range flag, fetch counter).
//
//   Modports
//     master : the fetch stage itself (drives ROM address, IF/ID, status)
//     slave  : the surrounding pipeline / ROM / testbench
//
//   Signals
//     stall        1       hazard unit: hold PC and IF/ID
//     redirect     1       EX: control transfer taken this cycle
//     redirect_pc  32      EX: target byte address
//     rom_addr     ADDR_W  ROM word address (pc[ADDR_W+1:2])
//     rom_dout     32      ROM instruction for rom_addr (combinational)
//     if_id_valid  1       IF/ID holds a real instruction
//     if_id_pc     32      PC of if_id_instr
//     if_id_pc4    32      if_id_pc + 4 (link value)
//     if_id_instr  32      fetched instruction or bubble encoding
//     fetch_oob    1       current pc lies outside the ROM
//     fetch_cnt    32      number of valid instructions written into IF/ID
// ---------------------------------------------------------------------------
interface if_stage_if #(
    parameter int ADDR_W = 6
);
    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_dout;
    logic              if_id_valid;
    logic [31:0]       if_id_pc;
    logic [31:0]       if_id_pc4;
    logic [31:0]       if_id_instr;
    logic              fetch_oob;
    logic [31:0]       fetch_cnt;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_pc,
        input  rom_dout,
        output rom_addr,
        output if_id_valid,
        output if_id_pc,
        output if_id_pc4,
        output if_id_instr,
        output fetch_oob,
        output fetch_cnt
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_pc,
        output rom_dout,
        input  rom_addr,
        input  if_id_valid,
        input  if_id_pc,
        input  if_id_pc4,
        input  if_id_instr,
        input  fetch_oob,
        input  fetch_cnt
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage of a 5-stage RV32I pipeline. Owns the PC, drives
//   the word address into a combinational instruction ROM, and captures the
//   returned instruction together with its PC into the IF/ID register.
//
//   Each rising edge does exactly one of:
//     redirect : pc <= aligned redirect target, IF/ID becomes a bubble
//                (valid=0, instr=NOP_INSTR, pc/pc4 keep their old value);
//                wins over stall because the instruction in IF is wrong-path.
//     stall    : pc, IF/ID and the fetch counter all hold.
//     fetch    : pc <= pc + 4; IF/ID <= {~oob, pc, pc+4, oob ? NOP : rom};
//                the fetch counter advances only for valid fetches.
//
//   Ports
//     clk    in  pipeline clock, rising-edge
//     rst_n  in  asynchronous active-low reset
//     bus    master side of if_stage_if (see the interface for the fields)
//
//   Parameters
//     RESET_PC   PC loaded on reset
//     ADDR_W     ROM word-address width
//     NOP_INSTR  bubble encoding written into IF/ID
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    if_stage_if.master    bus
);

    // Which of the three mutually exclusive edge actions applies.
    typedef enum logic [1:0] {
        OP_FETCH    = 2'd0,
        OP_HOLD     = 2'd1,
        OP_REDIRECT = 2'd2
    } op_e;

    // Architectural state
    logic [31:0] pc_r;
    logic        valid_r;
    logic [31:0] ipc_r;
    logic [31:0] ipc4_r;
    logic [31:0] instr_r;
    logic [31:0] cnt_r;

    // Next-state and helper signals
    op_e         op_s;
    logic        oob_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;
    logic [31:0] pc_nxt_s;
    logic        valid_nxt_s;
    logic [31:0] ipc_nxt_s;
    logic [31:0] ipc4_nxt_s;
    logic [31:0] instr_nxt_s;
    logic [31:0] cnt_nxt_s;

    // Any set bit above the ROM word range means the fetch would alias.
    assign oob_s      = |pc_r[31:ADDR_W+2];
    assign pc_plus4_s = pc_r + 32'd4;
    // Targets are forced to word alignment; masking keeps every bit in use.
    assign target_s   = bus.redirect_pc & 32'hFFFF_FFFC;

    // Select the edge action; redirect has priority over stall.
    always_comb begin
        op_s = OP_FETCH;
        if (bus.redirect) begin
            op_s = OP_REDIRECT;
        end else if (bus.stall) begin
            op_s = OP_HOLD;
        end else begin
            op_s = OP_FETCH;
        end
    end

    // Next-state values for PC, IF/ID and the fetch counter.
    always_comb begin
        pc_nxt_s    = pc_r;
        valid_nxt_s = valid_r;
        ipc_nxt_s   = ipc_r;
        ipc4_nxt_s  = ipc4_r;
        instr_nxt_s = instr_r;
        cnt_nxt_s   = cnt_r;
        case (op_s)
            OP_REDIRECT: begin
                // Kill the wrong-path fetch; pc/pc4 of IF/ID are left as-is.
                pc_nxt_s    = target_s;
                valid_nxt_s = 1'b0;
                instr_nxt_s = NOP_INSTR;
            end
            OP_HOLD: begin
                pc_nxt_s    = pc_r;
                valid_nxt_s = valid_r;
                instr_nxt_s = instr_r;
            end
            OP_FETCH: begin
                pc_nxt_s   = pc_plus4_s;
                ipc_nxt_s  = pc_r;
                ipc4_nxt_s = pc_plus4_s;
                if (oob_s) begin
                    // Out-of-range: never let the aliased ROM word through.
                    valid_nxt_s = 1'b0;
                    instr_nxt_s = NOP_INSTR;
                    cnt_nxt_s   = cnt_r;
                end else begin
                    valid_nxt_s = 1'b1;
                    instr_nxt_s = bus.rom_dout;
                    cnt_nxt_s   = cnt_r + 32'd1;
                end
            end
            default: begin
                pc_nxt_s    = pc_r;
                valid_nxt_s = valid_r;
                instr_nxt_s = instr_r;
            end
        endcase
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            ipc_r   <= 32'h0000_0000;
            ipc4_r  <= 32'h0000_0000;
            instr_r <= NOP_INSTR;
        end else begin
            valid_r <= valid_nxt_s;
            ipc_r   <= ipc_nxt_s;
            ipc4_r  <= ipc4_nxt_s;
            instr_r <= instr_nxt_s;
        end
    end

    // Debug counter of valid instructions entering IF/ID (wraps naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 32'h0000_0000;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // ROM address and range flag follow the PC register directly so the
    // ROM sees a valid address even while reset is held.
    assign bus.rom_addr    = pc_r[ADDR_W+1:2];
    assign bus.fetch_oob   = oob_s;
    assign bus.if_id_valid = valid_r;
    assign bus.if_id_pc    = ipc_r;
    assign bus.if_id_pc4   = ipc4_r;
    assign bus.if_id_instr = instr_r;
    assign bus.fetch_cnt   = cnt_r;

endmodule
